// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit five-stage pipeline.
// Issues data-memory requests for loads and stores on the X/M outputs. It
// stalls the upstream pipeline until the memory completes. It produces the
// write-back value and bubble-qualified control signals for M/W.
//
// Configuration macro: MEM_FWD_EN. When it is defined, write-back data is
// forwarded into store data. When it is undefined, store data is b_in and
// the wb_* inputs are unused.
//
// Ports:
//   clk, rst            pipeline clock, synchronous active-high reset
//   *_in                X/M control, ALU result/address, store data, PC+2,
//                       destination and store-source register indices
//   wb_RegWrite/wb_reg_dest/wb_data  write-back stage (store forwarding)
//   mem_req/mem_we/mem_addr/mem_wdata  data-memory request (combinational)
//   mem_rdata/mem_ready  data-memory read data and one-cycle completion pulse
//   stall               freeze PC, F/D, D/X and X/M
//   RegWrite_out, MemtoReg_out, halt_out, reg_dest_out, result_out  to M/W
//   stall_cycles        saturating count of stalled cycles
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        SavePC_in,
  input  logic        halt_in,
  input  logic [15:0] ALUresult_in,
  input  logic [15:0] b_in,
  input  logic [15:0] newPC_in,
  input  logic [3:0]  reg_dest_in,
  input  logic [3:0]  Source2_in,
  input  logic        wb_RegWrite,
  input  logic [3:0]  wb_reg_dest,
  input  logic [15:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        halt_out,
  output logic [3:0]  reg_dest_out,
  output logic [15:0] result_out,
  output logic [15:0] stall_cycles
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam logic [DW-1:0] SAT_MAX = {DW{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] load_q, load_d;
  logic          pending;
  logic [DW-1:0] fwd_wdata;

  assign pending = MemRead_in | MemWrite_in;

  // Store-data source for the issue cycle
`ifdef MEM_FWD_EN
  logic fwd_hit;
  assign fwd_hit   = MemWrite_in & wb_RegWrite & (wb_reg_dest == Source2_in)
                     & (wb_reg_dest != RW'(0));
  assign fwd_wdata = fwd_hit ? wb_data : b_in;
`else
  logic unused_fwd;
  assign fwd_wdata  = b_in;
  assign unused_fwd = ^{wb_RegWrite, wb_reg_dest, wb_data, Source2_in};
`endif

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  // Next-state and memory handshake outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    mem_req   = 1'b0;
    stall     = 1'b0;
    mem_addr  = addr_q;
    mem_we    = we_q;
    mem_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        // Issue straight from X/M; a ready in this cycle is not accepted
        mem_addr  = ALUresult_in;
        mem_we    = MemWrite_in;
        mem_wdata = fwd_wdata;
        if (pending) begin
          mem_req = 1'b1;
          stall   = 1'b1;
          addr_d  = ALUresult_in;
          we_d    = MemWrite_in;
          wdata_d = fwd_wdata;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          load_d  = mem_rdata;
          state_d = DONE;
        end
      end
      // Retire cycle; X/M still holds the finished access, so do not re-issue
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      stall   = 1'b0;
    end
  end

  // M/W outputs, bubbled while stalled or in reset
  assign RegWrite_out = RegWrite_in & ~stall & ~rst;
  assign halt_out     = halt_in     & ~stall & ~rst;
  assign MemtoReg_out = MemtoReg_in & ~stall & ~rst;
  assign reg_dest_out = reg_dest_in;
  assign result_out   = MemtoReg_in ? load_q : (SavePC_in ? newPC_in : ALUresult_in);

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != SAT_MAX)) begin
      stall_cycles <= stall_cycles + DW'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected M/W
// retirement of each instruction, and a monitor pops it when the stage
// retires (not stalled, instruction present). The monitor also checks
// bubble qualification on every stalled cycle.
module tb_mem_stage;

  typedef struct packed {
    logic        rw, mr, mw, m2r, spc, halt;
    logic [15:0] alu, b, npc;
    logic [3:0]  dest, src2;
    logic        wbrw;
    logic [3:0]  wbd;
    logic [15:0] wbdata;
  } instr_t;

  typedef struct packed {
    logic [15:0] result;
    logic        rw, halt, m2r;
    logic [3:0]  dest;
  } exp_t;

`ifdef MEM_FWD_EN
  localparam logic [15:0] SW_FWD_W = 16'h2222;
`else
  localparam logic [15:0] SW_FWD_W = 16'h1111;
`endif

  logic        clk, rst;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, SavePC_in, halt_in;
  logic [15:0] ALUresult_in, b_in, newPC_in;
  logic [3:0]  reg_dest_in, Source2_in;
  logic        wb_RegWrite;
  logic [3:0]  wb_reg_dest;
  logic [15:0] wb_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, stall;
  logic        RegWrite_out, MemtoReg_out, halt_out;
  logic [3:0]  reg_dest_out;
  logic [15:0] result_out, stall_cycles;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_stall_cnt = 0;
  logic xm_valid = 1'b0;
  exp_t sb_q[$];

  mem_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .SavePC_in(SavePC_in), .halt_in(halt_in),
    .ALUresult_in(ALUresult_in), .b_in(b_in), .newPC_in(newPC_in),
    .reg_dest_in(reg_dest_in), .Source2_in(Source2_in),
    .wb_RegWrite(wb_RegWrite), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .halt_out(halt_out),
    .reg_dest_out(reg_dest_out), .result_out(result_out), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: bubble checks while stalled, scoreboard pop on retirement
  always @(negedge clk) begin
    if (!rst) begin
      if (stall) begin
        tb_stall_cnt++;
        chk("bubble_regwrite", 16'(RegWrite_out), 16'h0);
        chk("bubble_halt",     16'(halt_out),     16'h0);
        chk("bubble_memtoreg", 16'(MemtoReg_out), 16'h0);
      end else if (xm_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: retirement with result %h, none expected", result_out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("ret_result",   result_out,          e.result);
          chk("ret_regwrite", 16'(RegWrite_out),   16'(e.rw));
          chk("ret_halt",     16'(halt_out),       16'(e.halt));
          chk("ret_memtoreg", 16'(MemtoReg_out),   16'(e.m2r));
          chk("ret_dest",     16'(reg_dest_out),   16'(e.dest));
        end
      end
    end
  end

  task automatic apply(input instr_t i);
    RegWrite_in  = i.rw;   MemRead_in  = i.mr;  MemWrite_in = i.mw;
    MemtoReg_in  = i.m2r;  SavePC_in   = i.spc; halt_in     = i.halt;
    ALUresult_in = i.alu;  b_in        = i.b;   newPC_in    = i.npc;
    reg_dest_in  = i.dest; Source2_in  = i.src2;
    wb_RegWrite  = i.wbrw; wb_reg_dest = i.wbd; wb_data     = i.wbdata;
  endtask

  task automatic clear();
    instr_t z;
    z = '0;
    apply(z);
  endtask

  // One instruction in X/M; n = cycles from issue to mem_ready (0 = no access)
  task automatic run(input string nm, input instr_t i, input int n, input logic [15:0] rd,
                     input logic early, input exp_t e, input logic [15:0] wd, input int es);
    logic [15:0] sc0;
    int          tc0;
    sb_q.push_back(e);
    apply(i);
    xm_valid  = 1'b1;
    mem_ready = early;
    mem_rdata = 16'hBAD0;
    sc0 = stall_cycles;
    tc0 = tb_stall_cnt;
    @(negedge clk);
    chk({nm, "_issue_req"}, 16'(mem_req), 16'(n > 0));
    chk({nm, "_issue_stall"}, 16'(stall), 16'(n > 0));
    if (n > 0) begin
      chk({nm, "_issue_addr"},  mem_addr,        i.alu);
      chk({nm, "_issue_we"},    16'(mem_we),     16'(i.mw));
      chk({nm, "_issue_wdata"}, mem_wdata,       wd);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (k == 1) wb_data = 16'h3333;
      if (k == n) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      if (k == 1) begin
        @(negedge clk);
        chk({nm, "_wait_req"},   16'(mem_req), 16'h1);
        chk({nm, "_wait_addr"},  mem_addr,     i.alu);
        chk({nm, "_wait_we"},    16'(mem_we),  16'(i.mw));
        chk({nm, "_wait_wdata"}, mem_wdata,    wd);
      end
    end
    if (n > 0) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_done_req"},   16'(mem_req), 16'h0);
      chk({nm, "_done_stall"}, 16'(stall),   16'h0);
    end
    @(posedge clk); #1;
    xm_valid = 1'b0;
    clear();
    if (es >= 0) begin
      chk({nm, "_stall_cycles_delta"}, stall_cycles - sc0,      16'(es));
      chk({nm, "_stall_seen"},         16'(tb_stall_cnt - tc0), 16'(es));
    end
  endtask

  initial begin
    instr_t i;
    exp_t   e;
    clear();
    mem_ready = 1'b0;
    mem_rdata = 16'h0;

    // Reset with a pending access: handshake and M/W controls forced low
    rst = 1'b1;
    RegWrite_in = 1'b1; MemRead_in = 1'b1; halt_in = 1'b1; MemtoReg_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req",      16'(mem_req),      16'h0);
    chk("rst_stall",    16'(stall),        16'h0);
    chk("rst_regwrite", 16'(RegWrite_out), 16'h0);
    chk("rst_halt",     16'(halt_out),     16'h0);
    chk("rst_memtoreg", 16'(MemtoReg_out), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
    chk("rst_stall_cycles", stall_cycles, 16'h0);

    // ADD: zero latency pass-through
    i = '0; i.rw = 1'b1; i.alu = 16'h1234; i.dest = 4'd3;
    e = '0; e.result = 16'h1234; e.rw = 1'b1; e.dest = 4'd3;
    run("add", i, 0, 16'h0, 1'b0, e, 16'h0, 0);

    // LW: ready three cycles after issue, four stall cycles
    i = '0; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.alu = 16'h0040; i.b = 16'h5555; i.dest = 4'd4;
    e = '0; e.result = 16'hBEEF; e.rw = 1'b1; e.m2r = 1'b1; e.dest = 4'd4;
    run("lw", i, 3, 16'hBEEF, 1'b0, e, 16'h5555, 4);
    chk("lw_stall_cycles_abs", stall_cycles, 16'd4);

    // Reset during WAIT, then a stray ready: no capture, no retirement
    i = '0; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.alu = 16'h0060; i.dest = 4'd2;
    apply(i);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_wait_stall", 16'(stall), 16'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req",   16'(mem_req), 16'h0);
    chk("midrst_stall", 16'(stall),   16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("postrst_req",   16'(mem_req), 16'h0);
    chk("postrst_stall", 16'(stall),   16'h0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("postrst_stall2", 16'(stall), 16'h0);
    chk("postrst_stall_cycles", stall_cycles, 16'h0);
    @(posedge clk); #1;

    // MemtoReg without an access reads load_data, still 0 after reset
    i = '0; i.rw = 1'b1; i.m2r = 1'b1; i.alu = 16'h0999; i.dest = 4'd6;
    e = '0; e.result = 16'h0000; e.rw = 1'b1; e.m2r = 1'b1; e.dest = 4'd6;
    run("m2r_noaccess", i, 0, 16'h0, 1'b0, e, 16'h0, 0);

    // SW with matching write-back register
    i = '0; i.mw = 1'b1; i.alu = 16'h0080; i.b = 16'h1111; i.src2 = 4'd5;
    i.wbrw = 1'b1; i.wbd = 4'd5; i.wbdata = 16'h2222; i.dest = 4'd1;
    e = '0; e.result = 16'h0080; e.dest = 4'd1;
    run("sw_fwd", i, 2, 16'h0, 1'b0, e, SW_FWD_W, 3);

    // SW with write-back to r0: never forwarded; MemRead also set, still a write
    i = '0; i.mw = 1'b1; i.mr = 1'b1; i.alu = 16'h0082; i.b = 16'h1111; i.src2 = 4'd0;
    i.wbrw = 1'b1; i.wbd = 4'd0; i.wbdata = 16'h2222; i.dest = 4'd1;
    e = '0; e.result = 16'h0082; e.dest = 4'd1;
    run("sw_r0", i, 2, 16'h0, 1'b0, e, 16'h1111, 3);

    // PCS: write back PC+2
    i = '0; i.rw = 1'b1; i.spc = 1'b1; i.npc = 16'h0102; i.alu = 16'h7777; i.dest = 4'd15;
    e = '0; e.result = 16'h0102; e.rw = 1'b1; e.dest = 4'd15;
    run("pcs", i, 0, 16'h0, 1'b0, e, 16'h0, 0);

    // LW with halt behind it and a ready in the issue cycle that must be ignored
    i = '0; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.halt = 1'b1; i.alu = 16'h00A0;
    i.b = 16'h4242; i.dest = 4'd7;
    e = '0; e.result = 16'hCAFE; e.rw = 1'b1; e.m2r = 1'b1; e.halt = 1'b1; e.dest = 4'd7;
    run("lw_halt", i, 1, 16'hCAFE, 1'b1, e, 16'h4242, 2);

    // Long access saturates the stall counter
    i = '0; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.alu = 16'h0100; i.dest = 4'd8;
    e = '0; e.result = 16'h1357; e.rw = 1'b1; e.m2r = 1'b1; e.dest = 4'd8;
    run("lw_long", i, 70000, 16'h1357, 1'b0, e, 16'h0000, -1);
    chk("sat_stall_cycles", stall_cycles, 16'hFFFF);
    i = '0; i.mr = 1'b1; i.alu = 16'h0102; i.dest = 4'd9;
    e = '0; e.result = 16'h0102; e.dest = 4'd9;
    run("lw_after_sat", i, 1, 16'h2468, 1'b0, e, 16'h0000, -1);
    chk("sat_hold", stall_cycles, 16'hFFFF);

    repeat (3) @(posedge clk);
    chk("sb_drained", 16'(sb_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
